// File: rtl/pipe_pkg.sv
// Shared widths and forwarding-select encodings for the decode-stage operand path.
// Also holds the per-operand forwarding priority function used by the top.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int REG_N  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_EALU = 2'd1,
    FWD_MALU = 2'd2,
    FWD_MMO  = 2'd3
  } fwd_t;

  // EX shadows MEM; a load still in EX is never forwarded (that case is the stall).
  function automatic fwd_t fwd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic              ewreg,
    input logic              em2reg,
    input logic [ADDR_W-1:0] ern,
    input logic              mwreg,
    input logic              mm2reg,
    input logic [ADDR_W-1:0] mrn
  );
    fwd_t sel;
    sel = FWD_RF;
    if (addr != '0) begin
      if (ewreg && !em2reg && ern == addr)
        sel = FWD_EALU;
      else if (mwreg && !mm2reg && mrn == addr)
        sel = FWD_MALU;
      else if (mwreg && mm2reg && mrn == addr)
        sel = FWD_MMO;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_regfile.sv
// 2-read / 1-write register file with async clear, hard-wired r0 and a
// combinational write-back bypass so a same-cycle WB write is visible to ID.
module pipe_regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic          wen,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb
);

  localparam int N = 2 ** AW;

  logic [DW-1:0] entry [N];
  logic          wr;

  assign wr = wen && (wa != '0);

  // Async clear rules out block RAM, so each entry is its own flop row.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        assign entry[gi] = '0;
      end else begin : g_reg
        always_ff @(posedge clock or negedge resetn) begin
          if (!resetn)
            entry[gi] <= '0;
          else if (wr && wa == AW'(gi))
            entry[gi] <= wd;
        end
      end
    end
  endgenerate

  assign qa = (wr && wa == ra) ? wd : entry[ra];
  assign qb = (wr && wa == rb) ? wd : entry[rb];

endmodule

// File: rtl/pipe_id_regfile_fwd.sv
// ID-stage operand source: register file, EX/MEM/WB forwarding muxes and
// load-use hazard detection driving wpcir.
module pipe_id_regfile_fwd
  import pipe_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              i_rs,
  input  logic              i_rt,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic [ADDR_W-1:0] ern,
  input  logic [DATA_W-1:0] ealu,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [ADDR_W-1:0] mrn,
  input  logic [DATA_W-1:0] malu,
  input  logic [DATA_W-1:0] mmo,
  input  logic              wwreg,
  input  logic [ADDR_W-1:0] wrn,
  input  logic [DATA_W-1:0] wdi,
  output logic [DATA_W-1:0] da,
  output logic [DATA_W-1:0] db,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              wpcir
);

  logic [DATA_W-1:0] qa;
  logic [DATA_W-1:0] qb;
  fwd_t              sel_a;
  fwd_t              sel_b;
  logic              load_use;

  pipe_regfile #(
    .DW(DATA_W),
    .AW(ADDR_W)
  ) u_regfile (
    .clock (clock),
    .resetn(resetn),
    .ra    (rs),
    .rb    (rt),
    .wen   (wwreg),
    .wa    (wrn),
    .wd    (wdi),
    .qa    (qa),
    .qb    (qb)
  );

  // Reset forces the outputs quiet even though the bypass/forward inputs may be live.
  assign sel_a = resetn ? fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn) : FWD_RF;
  assign sel_b = resetn ? fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn) : FWD_RF;

  always_comb begin
    da = qa;
    case (sel_a)
      FWD_EALU: da = ealu;
      FWD_MALU: da = malu;
      FWD_MMO:  da = mmo;
      default:  da = qa;
    endcase
    if (!resetn)
      da = '0;
  end

  always_comb begin
    db = qb;
    case (sel_b)
      FWD_EALU: db = ealu;
      FWD_MALU: db = malu;
      FWD_MMO:  db = mmo;
      default:  db = qb;
    endcase
    if (!resetn)
      db = '0;
  end

  assign load_use = ewreg && em2reg && (ern != '0) &&
                    ((i_rs && ern == rs) || (i_rt && ern == rt));

  assign fwda  = sel_a;
  assign fwdb  = sel_b;
  assign wpcir = !resetn || !load_use;

endmodule

// File: tb/tb_pipe_id_regfile_fwd.sv
// Randomized and directed bench for pipe_id_regfile_fwd, checked against an
// array-based model of the register file plus the forwarding/hazard rules.
module tb_pipe_id_regfile_fwd;

  logic        clock = 1'b0;
  logic        resetn;
  logic [4:0]  rs, rt, ern, mrn, wrn;
  logic        i_rs, i_rt, ewreg, em2reg, mwreg, mm2reg, wwreg;
  logic [31:0] ealu, malu, mmo, wdi;
  logic [31:0] da, db;
  logic [1:0]  fwda, fwdb;
  logic        wpcir;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] rf_model [32];

  pipe_id_regfile_fwd dut (
    .clock (clock),
    .resetn(resetn),
    .rs    (rs),
    .rt    (rt),
    .i_rs  (i_rs),
    .i_rt  (i_rt),
    .ewreg (ewreg),
    .em2reg(em2reg),
    .ern   (ern),
    .ealu  (ealu),
    .mwreg (mwreg),
    .mm2reg(mm2reg),
    .mrn   (mrn),
    .malu  (malu),
    .mmo   (mmo),
    .wwreg (wwreg),
    .wrn   (wrn),
    .wdi   (wdi),
    .da    (da),
    .db    (db),
    .fwda  (fwda),
    .fwdb  (fwdb),
    .wpcir (wpcir)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) rf_model[i] = 32'h0;
  endtask

  task automatic idle();
    rs = 0; rt = 0; i_rs = 0; i_rt = 0;
    ewreg = 0; em2reg = 0; ern = 0; ealu = 0;
    mwreg = 0; mm2reg = 0; mrn = 0; malu = 0; mmo = 0;
    wwreg = 0; wrn = 0; wdi = 0;
  endtask

  // Clock edge: commit the write the DUT sees, then move away from the edge.
  task automatic tick();
    @(posedge clock);
    if (resetn && wwreg && wrn != 0) rf_model[wrn] = wdi;
    #1;
  endtask

  function automatic void model_operand(input logic [4:0] a, output logic [31:0] v,
                                        output logic [1:0] s);
    v = 0; s = 0;
    if (!resetn || a == 0) return;
    if (ewreg && !em2reg && ern == a)      begin v = ealu; s = 1; end
    else if (mwreg && !mm2reg && mrn == a) begin v = malu; s = 2; end
    else if (mwreg && mm2reg && mrn == a)  begin v = mmo;  s = 3; end
    else if (wwreg && wrn == a)            v = wdi;
    else                                   v = rf_model[a];
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] va, vb;
    logic [1:0]  sa, sb;
    logic        stall;
    #1;
    model_operand(rs, va, sa);
    model_operand(rt, vb, sb);
    stall = resetn && ewreg && em2reg && ern != 0 &&
            ((i_rs && ern == rs) || (i_rt && ern == rt));
    check({tag, ".da"}, da, va);
    check({tag, ".db"}, db, vb);
    check({tag, ".fwda"}, 32'(fwda), 32'(sa));
    check({tag, ".fwdb"}, 32'(fwdb), 32'(sb));
    check({tag, ".wpcir"}, 32'(wpcir), 32'(!stall));
  endtask

  initial begin
    idle();
    clear_model();
    resetn = 0;
    #3;
    check_all("por");
    check("por.wpcir_const", 32'(wpcir), 32'h1);
    tick(); tick();
    resetn = 1;
    $display("step reset_release");

    // Reset wipes a written register and quiets outputs while held.
    wwreg = 1; wrn = 5; wdi = 32'h1234;
    tick();
    idle(); rs = 5;
    check_all("rst.pre");
    check("rst.pre_const", da, 32'h1234);
    wwreg = 1; wrn = 5; wdi = 32'h5555;
    ewreg = 1; em2reg = 1; ern = 5; i_rs = 1; rt = 5;
    resetn = 0; clear_model();
    check_all("rst.held");
    check("rst.held_da", da, 32'h0);
    check("rst.held_wpcir", 32'(wpcir), 32'h1);
    tick();
    resetn = 1; idle(); rs = 5;
    check_all("rst.post");
    check("rst.post_da", da, 32'h0);
    $display("step reset done");

    // r0 is never written nor forwarded.
    wwreg = 1; wrn = 0; wdi = 32'hFFFF_FFFF; rs = 0;
    check_all("r0.wb");
    ewreg = 1; ern = 0; ealu = 32'h77;
    check_all("r0.ex");
    check("r0.fwda", 32'(fwda), 32'h0);
    tick();
    idle();
    check("r0.after", da, 32'h0);
    $display("step r0 done");

    // Same-cycle WB bypass, then the stored value.
    wwreg = 1; wrn = 7; wdi = 32'hA5A5_A5A5; rs = 7;
    check_all("byp.same");
    check("byp.same_da", da, 32'hA5A5_A5A5);
    tick();
    idle(); rs = 7;
    check_all("byp.next");
    check("byp.next_da", da, 32'hA5A5_A5A5);
    $display("step bypass done");

    // EX over MEM over WB.
    ern = 3; mrn = 3; wrn = 3; ewreg = 1; mwreg = 1; wwreg = 1;
    ealu = 1; malu = 2; wdi = 3; rs = 3;
    check_all("pri.ex");
    check("pri.ex_da", da, 32'h1);
    check("pri.ex_fwda", 32'(fwda), 32'h1);
    ewreg = 0;
    check_all("pri.mem");
    check("pri.mem_da", da, 32'h2);
    check("pri.mem_fwda", 32'(fwda), 32'h2);
    tick();
    idle();
    $display("step priority done");

    // Load-use stall, then MEM-stage load data forwarded.
    ewreg = 1; em2reg = 1; ern = 4; rt = 4; i_rt = 1;
    check_all("lu.stall");
    check("lu.stall_wpcir", 32'(wpcir), 32'h0);
    i_rt = 0;
    check_all("lu.noread");
    check("lu.noread_wpcir", 32'(wpcir), 32'h1);
    i_rt = 1;
    tick();
    idle(); rt = 4; i_rt = 1;
    mwreg = 1; mm2reg = 1; mrn = 4; mmo = 32'hDEAD_BEEF;
    check_all("lu.mem");
    check("lu.mem_db", db, 32'hDEAD_BEEF);
    check("lu.mem_fwdb", 32'(fwdb), 32'h3);
    tick();
    idle();
    $display("step load_use done");

    // Random program; small address range to provoke matches.
    for (int c = 0; c < 10000; c++) begin
      resetn = ($urandom_range(199) != 0);
      if (!resetn) clear_model();
      rs = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      rt = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      ern = 5'($urandom_range(7)); mrn = 5'($urandom_range(7)); wrn = 5'($urandom_range(7));
      i_rs = 1'($urandom); i_rt = 1'($urandom);
      ewreg = 1'($urandom); em2reg = 1'($urandom);
      mwreg = 1'($urandom); mm2reg = 1'($urandom);
      wwreg = 1'($urandom);
      ealu = $urandom; malu = $urandom; mmo = $urandom; wdi = $urandom;
      check_all("rand");
      tick();
      if (c % 1000 == 999)
        $display("step random cycles=%0d mismatched=%0d", c + 1, mismatched);
    end

    resetn = 1;
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
